// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC, pipelined imem reads and an in-order instruction queue.
// Define FETCH_STATS_EN to add the stat_fetched / stat_flushed counters.
module fetch_queue_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       PC_STEP  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   output logic               busy
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        stat_fetched,
   output logic [31:0]        stat_flushed
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CW-1:0]      out_q, out_d;
   logic [CW-1:0]      disc_q, disc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      hd_q, hd_d, tl_q, tl_d;
   logic [PW-1:0]      tw_q, tw_d, tr_q, tr_d;
   logic [INSTR_W-1:0] qd_q  [DEPTH];
   logic [ADDR_W-1:0]  qp_q  [DEPTH];
   logic [ADDR_W-1:0]  tag_q [DEPTH];
   logic               space, issue, pop;
   logic               flush, keep, drop;

   assign space = ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
   assign imem_req = (state_q == RUN) && space
                     && !halt && !branch_taken;
   assign imem_addr = pc_q;
   assign issue = imem_req && imem_ready;

   assign instr_valid = cnt_q != '0;
   assign instr = instr_valid ? qd_q[hd_q] : '0;
   assign instr_pc = instr_valid ? qp_q[hd_q] : '0;
   assign pop = instr_valid && instr_ready;
   assign busy = state_q != IDLE;

   // Redirect kills everything queued and marks all in-flight reads stale
   assign flush = branch_taken && (state_q != IDLE);
   assign drop = imem_rvalid && (disc_q != '0);
   assign keep = imem_rvalid && (disc_q == '0) && !flush;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (halt) state_d = DRAIN;
         DRAIN:   if (out_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (branch_taken) pc_d = branch_target;
      else if (issue) pc_d = pc_q + ADDR_W'(PC_STEP);
      out_d = out_q + CW'(issue) - CW'(imem_rvalid);
      disc_d = flush ? out_q - CW'(imem_rvalid)
                     : disc_q - CW'(drop);
      cnt_d = flush ? '0 : cnt_q + CW'(keep) - CW'(pop);
      hd_d = flush ? '0 : hd_q + PW'(pop);
      tl_d = flush ? '0 : tl_q + PW'(keep);
      tw_d = tw_q + PW'(issue);
      tr_d = tr_q + PW'(imem_rvalid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         disc_q  <= '0;
         cnt_q   <= '0;
         hd_q    <= '0;
         tl_q    <= '0;
         tw_q    <= '0;
         tr_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         cnt_q   <= cnt_d;
         hd_q    <= hd_d;
         tl_q    <= tl_d;
         tw_q    <= tw_d;
         tr_q    <= tr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (keep) begin
         qd_q[tl_q] <= imem_rdata;
         qp_q[tl_q] <= tag_q[tr_q];
      end
      if (issue) tag_q[tw_q] <= pc_q;
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fet_q, fls_q;
   logic [32:0] fls_sum;

   // Killed = unpopped queue entries plus in-flight reads not yet stale
   assign fls_sum = {1'b0, fls_q} + 33'(cnt_q) - 33'(pop)
                    + 33'(out_q) - 33'(disc_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fet_q <= '0;
         fls_q <= '0;
      end else begin
         if (issue && (fet_q != '1)) fet_q <= fet_q + 32'd1;
         if (flush) fls_q <= fls_sum[32] ? '1 : fls_sum[31:0];
      end
   end

   assign stat_fetched = fet_q;
   assign stat_flushed = fls_q;
`endif

   a_rsp_expected: assert property (
      @(posedge clk) disable iff (rst)
      imem_rvalid |-> (out_q != '0));

endmodule
